// File: rtl/ysyx_24080006_clint_if.sv
// Bus bundle for the CLINT slave. It carries the read channel (AR/R) and the
// write channel (AW/W/B) with valid/ready handshakes and 4-bit transaction IDs.
// master: drives requests and the response-ready signals.
// slave:  drives the ready signals and the responses (rdata/rresp/rid, bresp/bid).
interface ysyx_24080006_clint_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport master (
    output arvalid, araddr, arid, rready,
    output awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, rid,
    input  awready, wready, bvalid, bresp, bid
  );

  modport slave (
    input  arvalid, araddr, arid, rready,
    input  awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, rid,
    output awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/ysyx_24080006_clint.sv
// Read-only core-local interruptor timer. It keeps a free-running 64-bit mtime
// counter that advances once every MTIME_DIV clocks. mtime is readable at
// offsets 0xBFF8 (low word) and 0xBFFC (high word) of a 64 KiB window that
// starts at BASE. Every write is refused: SLVERR inside the window and DECERR
// outside it.
// Ports:
//   clock - sole clock, rising edge
//   reset - asynchronous, active-high
//   bus   - slave side of the AR/R/AW/W/B bus bundle
module ysyx_24080006_clint #(
  parameter int unsigned MTIME_DIV = 1,
  parameter logic [31:0] BASE      = 32'h0200_0000
) (
  input logic                   clock,
  input logic                   reset,
  ysyx_24080006_clint_if.slave  bus
);

  localparam logic [15:0] PRE_MAX  = 16'(MTIME_DIV - 1);
  localparam logic [1:0]  RESP_OK  = 2'b00;
  localparam logic [1:0]  RESP_SLV = 2'b10;
  localparam logic [1:0]  RESP_DEC = 2'b11;

  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_t;

  logic [63:0] mtime;
  logic [15:0] prescaler;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  logic [31:0] ar_off, aw_off;
  logic        ar_in_win, aw_in_win;
  logic [31:0] rdata_d;
  logic [1:0]  rresp_d;

  // wdata, wstrb and the low awaddr bits never affect the outcome of a write.
  logic unused_wr;
  assign unused_wr = ^{bus.wdata, bus.wstrb};

  // ---------------------------------------------------------------- timer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime     <= '0;
      prescaler <= '0;
    end else if (prescaler == PRE_MAX) begin
      prescaler <= '0;
      mtime     <= mtime + 64'd1;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  // ---------------------------------------------------------- handshakes
  assign ar_hs = bus.arvalid & bus.arready;
  assign r_hs  = bus.rvalid  & bus.rready;
  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid  & bus.wready;
  assign b_hs  = bus.bvalid  & bus.bready;

  // The window check uses the offset so it also works for a non-64K-aligned BASE.
  assign ar_off    = bus.araddr - BASE;
  assign aw_off    = bus.awaddr - BASE;
  assign ar_in_win = (bus.araddr >= BASE) && (ar_off[31:16] == 16'h0000);
  assign aw_in_win = (bus.awaddr >= BASE) && (aw_off[31:16] == 16'h0000);

  // ---------------------------------------------------------- read decode
  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_OK;
    if (!ar_in_win) begin
      rresp_d = RESP_DEC;
    end else if (bus.araddr[1:0] != 2'b00) begin
      rresp_d = RESP_SLV;
    end else if (ar_off[15:0] == 16'hBFF8) begin
      rdata_d = mtime[31:0];
    end else if (ar_off[15:0] == 16'hBFFC) begin
      rdata_d = mtime[63:32];
    end
  end

  // ------------------------------------------------------------ read FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_next = R_RESP;
      R_RESP: if (r_hs)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    bus.arready = (r_state == R_IDLE);
    bus.rvalid  = (r_state == R_RESP);
  end

  // Response captured at acceptance; mtime here is the pre-increment value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.rdata <= '0;
      bus.rresp <= '0;
      bus.rid   <= '0;
    end else if (ar_hs) begin
      bus.rdata <= rdata_d;
      bus.rresp <= rresp_d;
      bus.rid   <= bus.arid;
    end
  end

  // ----------------------------------------------------------- write FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs)    w_next = W_GOT_AW;
        else if (w_hs)     w_next = W_GOT_W;
      end
      W_GOT_AW: if (w_hs)  w_next = W_RESP;
      W_GOT_W:  if (aw_hs) w_next = W_RESP;
      W_RESP:   if (b_hs)  w_next = W_IDLE;
      default:  w_next = W_IDLE;
    endcase
  end

  always_comb begin
    bus.awready = (w_state == W_IDLE) || (w_state == W_GOT_W);
    bus.wready  = (w_state == W_IDLE) || (w_state == W_GOT_AW);
    bus.bvalid  = (w_state == W_RESP);
  end

  // The write outcome depends only on the address, so it is settled at AW time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.bresp <= '0;
      bus.bid   <= '0;
    end else if (aw_hs) begin
      bus.bresp <= aw_in_win ? RESP_SLV : RESP_DEC;
      bus.bid   <= bus.awid;
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_clint.sv
module tb_ysyx_24080006_clint;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_24080006_clint_if bus_a ();
  ysyx_24080006_clint_if bus_b ();

  ysyx_24080006_clint #(.MTIME_DIV(1), .BASE(32'h0200_0000)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );
  ysyx_24080006_clint #(.MTIME_DIV(4), .BASE(32'h0200_0000)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned edges;

  // Rising edges seen since reset release; at a falling edge this equals the
  // mtime value (MTIME_DIV=1) that a read accepted at the next rising edge returns.
  always @(posedge clock or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one read on bus_a from a falling edge with rready high; returns the
  // captured response and the edge count at issue time.
  task automatic rd_a(input logic [31:0] addr, input logic [3:0] id,
                      output logic [31:0] d, output logic [1:0] r,
                      output logic [3:0] i, output int unsigned at);
    bus_a.araddr  = addr;
    bus_a.arid    = id;
    bus_a.arvalid = 1'b1;
    bus_a.rready  = 1'b1;
    at = edges;
    @(negedge clock);
    bus_a.arvalid = 1'b0;
    for (int k = 0; k < 8 && !bus_a.rvalid; k++) @(negedge clock);
    check("rd_timeout", bus_a.rvalid, 1'b1);
    d = bus_a.rdata;
    r = bus_a.rresp;
    i = bus_a.rid;
    @(negedge clock);
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  logic [3:0]  i;
  int unsigned at;

  initial begin
    reset = 1'b1;
    bus_a.arvalid = 0; bus_a.araddr = '0; bus_a.arid = '0; bus_a.rready = 0;
    bus_a.awvalid = 0; bus_a.awaddr = '0; bus_a.awid = '0;
    bus_a.wvalid  = 0; bus_a.wdata  = '0; bus_a.wstrb = '0; bus_a.bready = 0;
    bus_b.arvalid = 0; bus_b.araddr = '0; bus_b.arid = '0; bus_b.rready = 0;
    bus_b.awvalid = 0; bus_b.awaddr = '0; bus_b.awid = '0;
    bus_b.wvalid  = 0; bus_b.wdata  = '0; bus_b.wstrb = '0; bus_b.bready = 0;

    // reset state
    repeat (3) @(negedge clock);
    check("rst_rvalid", bus_a.rvalid, 1'b0);
    check("rst_bvalid", bus_a.bvalid, 1'b0);
    check("rst_rdata",  bus_a.rdata,  32'h0);
    check("rst_rresp",  bus_a.rresp,  2'b00);
    check("rst_rid",    bus_a.rid,    4'h0);
    check("rst_bresp",  bus_a.bresp,  2'b00);
    check("rst_bid",    bus_a.bid,    4'h0);
    reset = 1'b0;
    #1;
    check("rel_arready", bus_a.arready, 1'b1);
    check("rel_awready", bus_a.awready, 1'b1);
    check("rel_wready",  bus_a.wready,  1'b1);

    // divided timer: accept at edge 8 -> 2, at edge 12 -> 3
    repeat (8) @(negedge clock);
    bus_b.araddr = 32'h0200_BFF8; bus_b.arid = 4'h1;
    bus_b.arvalid = 1'b1; bus_b.rready = 1'b1;
    @(negedge clock);
    bus_b.arvalid = 1'b0;
    check("div4_rvalid8", bus_b.rvalid, 1'b1);
    check("div4_rdata8",  bus_b.rdata,  32'd2);
    check("div4_rresp8",  bus_b.rresp,  2'b00);
    @(negedge clock);
    check("div4_rdone", bus_b.rvalid, 1'b0);

    // undivided timer: accept 10 edges after release -> 10
    rd_a(32'h0200_BFF8, 4'h3, d, r, i, at);
    check("div1_rdata10", d, 32'd10);
    check("div1_rresp",   r, 2'b00);
    check("div1_rid",     i, 4'h3);

    bus_b.araddr = 32'h0200_BFF8; bus_b.arvalid = 1'b1;
    @(negedge clock);
    bus_b.arvalid = 1'b0;
    check("div4_rdata12", bus_b.rdata, 32'd3);

    // decode priority and window boundaries
    rd_a(32'h1000_0000, 4'hA, d, r, i, at);
    check("dec_resp", r, 2'b11); check("dec_data", d, 32'h0); check("dec_rid", i, 4'hA);
    rd_a(32'h0200_BFF9, 4'hA, d, r, i, at);
    check("slv_resp", r, 2'b10); check("slv_data", d, 32'h0); check("slv_rid", i, 4'hA);
    rd_a(32'h0200_0000, 4'h3, d, r, i, at);
    check("zero_resp", r, 2'b00); check("zero_data", d, 32'h0);
    rd_a(32'h0200_FFFC, 4'h7, d, r, i, at);
    check("top_resp", r, 2'b00); check("top_data", d, 32'h0);
    rd_a(32'h0201_0000, 4'h1, d, r, i, at);
    check("above_resp", r, 2'b11);
    rd_a(32'h01FF_FFFC, 4'h1, d, r, i, at);
    check("below_resp", r, 2'b11);
    rd_a(32'h0200_BFFC, 4'h2, d, r, i, at);
    check("hi_small", d, 32'h0); check("hi_resp", r, 2'b00);
    rd_a(32'h0200_BFF8, 4'h2, d, r, i, at);
    check("lo_model", d, at);

    // write: W three cycles before AW, bready held low
    bus_a.wvalid = 1'b1; bus_a.wdata = 32'hDEAD_BEEF; bus_a.wstrb = 4'hF; bus_a.bready = 1'b0;
    @(negedge clock);
    bus_a.wvalid = 1'b0;
    check("gotw_wready",  bus_a.wready,  1'b0);
    check("gotw_awready", bus_a.awready, 1'b1);
    repeat (2) @(negedge clock);
    check("gotw_nobvalid", bus_a.bvalid, 1'b0);
    bus_a.awvalid = 1'b1; bus_a.awaddr = 32'h0200_BFF8; bus_a.awid = 4'h5;
    @(negedge clock);
    bus_a.awvalid = 1'b0;
    check("wr_bvalid", bus_a.bvalid, 1'b1);
    check("wr_bresp",  bus_a.bresp,  2'b10);
    check("wr_bid",    bus_a.bid,    4'h5);
    check("wresp_awready", bus_a.awready, 1'b0);
    check("wresp_wready",  bus_a.wready,  1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("hold_bvalid", bus_a.bvalid, 1'b1);
      check("hold_bresp",  bus_a.bresp,  2'b10);
    end
    bus_a.bready = 1'b1;
    @(negedge clock);
    check("wr_done", bus_a.bvalid, 1'b0);
    rd_a(32'h0200_BFF8, 4'h2, d, r, i, at);
    check("wr_mtime_kept", d, at);

    // write: AW first, outside the window
    bus_a.awvalid = 1'b1; bus_a.awaddr = 32'h3000_0000; bus_a.awid = 4'h9;
    @(negedge clock);
    bus_a.awvalid = 1'b0;
    check("gotaw_awready", bus_a.awready, 1'b0);
    check("gotaw_wready",  bus_a.wready,  1'b1);
    bus_a.wvalid = 1'b1;
    @(negedge clock);
    bus_a.wvalid = 1'b0;
    check("dec_bvalid", bus_a.bvalid, 1'b1);
    check("dec_bresp",  bus_a.bresp,  2'b11);
    check("dec_bid",    bus_a.bid,    4'h9);
    @(negedge clock);
    check("dec_bdone", bus_a.bvalid, 1'b0);

    // concurrent read and same-cycle AW+W
    bus_a.araddr = 32'h0200_BFF8; bus_a.arid = 4'h2; bus_a.arvalid = 1'b1; bus_a.rready = 1'b1;
    bus_a.awaddr = 32'h0200_0004; bus_a.awid = 4'hC; bus_a.awvalid = 1'b1; bus_a.wvalid = 1'b1;
    at = edges;
    @(negedge clock);
    bus_a.arvalid = 1'b0; bus_a.awvalid = 1'b0; bus_a.wvalid = 1'b0;
    check("cc_rvalid", bus_a.rvalid, 1'b1);
    check("cc_rdata",  bus_a.rdata,  at);
    check("cc_rid",    bus_a.rid,    4'h2);
    check("cc_bvalid", bus_a.bvalid, 1'b1);
    check("cc_bresp",  bus_a.bresp,  2'b10);
    check("cc_bid",    bus_a.bid,    4'hC);
    @(negedge clock);
    check("cc_rdone", bus_a.rvalid, 1'b0);
    check("cc_bdone", bus_a.bvalid, 1'b0);

    // carry from low word into high word
    force dut_a.mtime = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut_a.mtime;
    @(negedge clock);
    rd_a(32'h0200_BFFC, 4'h4, d, r, i, at);
    check("carry_hi", d, 32'h0000_0001);
    rd_a(32'h0200_BFF8, 4'h4, d, r, i, at);
    check("carry_lo_range", (d >= 32'd1) && (d < 32'd16), 1'b1);

    // reset while a response is pending
    bus_a.araddr = 32'h0200_BFF8; bus_a.arid = 4'h6; bus_a.arvalid = 1'b1; bus_a.rready = 1'b0;
    @(negedge clock);
    bus_a.arvalid = 1'b0;
    check("pend_rvalid",  bus_a.rvalid,  1'b1);
    check("pend_arready", bus_a.arready, 1'b0);
    @(negedge clock);
    check("pend_hold", bus_a.rvalid, 1'b1);
    check("pend_rid",  bus_a.rid,    4'h6);
    #2;
    reset = 1'b1;
    #1;
    check("async_rvalid", bus_a.rvalid, 1'b0);
    check("async_rid",    bus_a.rid,    4'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rvalid",  bus_a.rvalid,  1'b0);
    check("post_arready", bus_a.arready, 1'b1);
    @(negedge clock);
    rd_a(32'h0200_BFF8, 4'h8, d, r, i, at);
    check("post_rdata", d, at);
    check("post_rresp", r, 2'b00);
    check("post_rid",   i, 4'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_clint.md
YSYX_24080006_CLINT -- requirements
Module: ysyx_24080006_clint

Interface
REQ-001 SHALL have parameter MTIME_DIV, default 1, meaning clock cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have parameter BASE, default 32'h0200_0000, meaning the first address of the 64 KiB CLINT window.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 arvalid/arready  input/output  1/1  read-address handshake.
REQ-006 araddr  input  32  read byte address.
REQ-007 arid  input  4  read transaction ID.
REQ-008 rvalid/rready  output/input  1/1  read-data handshake.
REQ-009 rdata  output  32  read data.
REQ-010 rresp  output  2  read response: 00 OKAY, 10 SLVERR, 11 DECERR.
REQ-011 rid  output  4  ID echoed from arid.
REQ-012 awvalid/awready, wvalid/wready  input/output  1 each  write-address and write-data handshakes.
REQ-013 awaddr  input  32  write address.
REQ-014 awid  input  4  write ID.
REQ-015 wdata  input  32  write data.
REQ-016 wstrb  input  4  write strobes.
REQ-017 bvalid/bready  output/input  1/1  write-response handshake.
REQ-018 bresp  output  2  write response, same encoding as rresp.
REQ-019 bid  output  4  ID echoed from awid.

Function
REQ-020 SHALL keep a 64-bit mtime counter plus a prescaler; prescaler counts 0..MTIME_DIV-1; mtime increments by 1 in the cycle the prescaler equals MTIME_DIV-1, and the prescaler returns to 0 in that cycle.
REQ-021 mtime SHALL wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-022 Read FSM SHALL have two states, R_IDLE and R_RESP; arready=1 only in R_IDLE.
REQ-023 R_IDLE→R_RESP SHALL occur on arvalid&arready; rvalid SHALL assert the next cycle (1-cycle latency); rdata/rresp/rid SHALL be registered at acceptance and held stable while rvalid&!rready.
REQ-024 R_RESP→R_IDLE SHALL occur on rvalid&rready; no new AR SHALL be accepted in that same cycle.
REQ-025 Read decode SHALL apply in this priority:
- araddr outside BASE..BASE+16'hFFFF → DECERR, rdata 0.
- araddr[1:0]!=0 → SLVERR, rdata 0.
- offset 16'hBFF8 → OKAY, mtime[31:0].
- offset 16'hBFFC → OKAY, mtime[63:32].
- any other aligned offset → OKAY, rdata 0.
REQ-026 A read SHALL return the mtime value present in the acceptance cycle, before that cycle's increment.
REQ-027 Write FSM SHALL have states W_IDLE, W_GOT_AW, W_GOT_W, W_RESP; AW and W SHALL be acceptable in either order or in the same cycle.
REQ-028 awready SHALL be 1 in W_IDLE and W_GOT_W; wready SHALL be 1 in W_IDLE and W_GOT_AW; both SHALL be 0 in W_RESP.
REQ-029 Write FSM transitions SHALL be:
- W_IDLE with both AW and W handshakes in one cycle → W_RESP.
- W_IDLE with AW handshake only → W_GOT_AW; with W handshake only → W_GOT_W.
- W_GOT_AW on a W handshake, or W_GOT_W on an AW handshake → W_RESP.
- bvalid asserts in W_RESP.
- W_RESP→W_IDLE on bvalid&bready.
REQ-030 Writes SHALL never modify any state; awaddr outside the window → bresp DECERR; inside the window → bresp SLVERR (the CLINT is read-only), regardless of wdata and wstrb.
REQ-031 bid SHALL equal the awid captured at the AW handshake.
REQ-032 Read and write FSMs SHALL operate independently; concurrent read and write traffic SHALL not stall or alter each other.

Reset
REQ-033 On reset assertion, the block SHALL immediately, without waiting for a clock edge, set:
- mtime and prescaler to 0;
- both FSMs to their idle states;
- rvalid, bvalid, rdata, rresp, rid, bresp and bid to 0;
- arready, awready and wready to 1 once reset deasserts.
REQ-034 Reset SHALL abort any in-flight transaction; no response for it SHALL appear after reset.

Verification
REQ-035 MTIME_DIV=1: release reset, wait 10 cycles, then read BASE+0xBFF8 → rresp 00, rdata equals the cycle count from reset release to AR acceptance.
REQ-036 MTIME_DIV=4: read 0xBFF8 at acceptance cycles 8 and 12 after reset release → values 2 and 3.
REQ-037 Force mtime to 0x0000_0000_FFFF_FFFF, then read 0xBFFC one cycle later → 0x0000_0001; read 0xBFF8 → 0x0000_0001 or higher.
REQ-038 Read araddr 0x1000_0000 → DECERR with rdata 0; read 0x0200_BFF9 → SLVERR; in both cases rid echoes arid=4'hA.
REQ-039 Write with W issued 3 cycles before AW, awaddr 0x0200_BFF8, awid 4'h5 → bvalid one cycle after the AW handshake, bresp 10, bid 5, mtime unaffected; with bready low for 5 cycles, bvalid and bresp are held.
REQ-040 Assert reset while rvalid=1 and rready=0 → rvalid drops immediately; after release, a new read completes normally.
